tpu_result_dump_engine: RTL and testbench

Parametrised writeback engine that streams an M x N accumulator result tile from the on-chip result buffer to DDR over an AXI4 write master. It generalises the fixed 16x16 dump to arbitrary M, N ≤ SYSTOLIC_ARRAY_WIDTH, configurable row stride, partial-beat strobes, 4 KB boundary splitting and write-response error capture. It sits between the result buffer and the AXI master port inside top_tpu, and is triggered by the dump command from the control/status registers.

---
 rtl/tpu_dump_pkg.sv | 23 ++
 rtl/tpu_result_dump_engine_packer.sv | 33 +++
 rtl/tpu_result_dump_engine.sv | 216 +++++++++++++++++++++
 tb/tb_tpu_result_dump_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_dump_pkg.sv
// Shared types and constants for the result-tile writeback engine.
// Covers the FSM encoding, the AXI encodings and the beat-count helper.
package tpu_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } dump_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] BOUNDARY_4K    = 32'd4096;

  // Beats needed to carry n_len elements at epb elements per beat.
  function automatic int unsigned beats_for(input int unsigned n_len, input int unsigned epb);
    return (n_len + epb - 1) / epb;
  endfunction

endpackage

// File: rtl/tpu_result_dump_engine_packer.sv
// Selects one AXI beat worth of elements from a latched result row.
// Lanes past the row length carry zero data and zero strobes.
module tpu_dump_beat_packer
  import tpu_dump_pkg::*;
#(
  parameter int AXI_DATA_WIDTH       = 64,
  parameter int ACCUM_WIDTH          = 32,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int LEN_W                = 5
) (
  input  logic [SYSTOLIC_ARRAY_WIDTH*ACCUM_WIDTH-1:0] row_data,
  input  logic [LEN_W-1:0]                            beat_idx,
  input  logic [LEN_W-1:0]                            n_len,
  output logic [AXI_DATA_WIDTH-1:0]                   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                 wstrb
);

  localparam int EPB = AXI_DATA_WIDTH / ACCUM_WIDTH;
  localparam int EB  = ACCUM_WIDTH / 8;

  always_comb begin
    wdata = '0;
    wstrb = '0;
    for (int l = 0; l < EPB; l++) begin
      if ((int'(beat_idx) * EPB + l) < int'(n_len)) begin
        wdata[l*ACCUM_WIDTH +: ACCUM_WIDTH] =
          row_data[(int'(beat_idx) * EPB + l)*ACCUM_WIDTH +: ACCUM_WIDTH];
        wstrb[l*EB +: EB] = '1;
      end
    end
  end

endmodule

// File: rtl/tpu_result_dump_engine.sv
// Streams an M x N accumulator tile from the result buffer to DDR, one AXI4
// burst outstanding at a time, splitting rows that straddle a 4 KB page.
module tpu_result_dump_engine
  import tpu_dump_pkg::*;
#(
  parameter int AXI_DATA_WIDTH       = 64,
  parameter int ACCUM_WIDTH          = 32,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int ADDR_WIDTH           = 10,
  parameter int BUF_RD_LATENCY       = 1,
  localparam int LEN_W               = $clog2(SYSTOLIC_ARRAY_WIDTH) + 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [LEN_W-1:0]                            m_len,
  input  logic [LEN_W-1:0]                            n_len,
  input  logic [ADDR_WIDTH-1:0]                       buf_base,
  input  logic [31:0]                                 ddr_addr,
  input  logic [31:0]                                 ddr_stride,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  output logic                                        buf_rd_en,
  output logic [ADDR_WIDTH-1:0]                       buf_rd_addr,
  input  logic [SYSTOLIC_ARRAY_WIDTH*ACCUM_WIDTH-1:0] buf_rd_data,
  output logic [31:0]                                 m_axi_awaddr,
  output logic [7:0]                                  m_axi_awlen,
  output logic [2:0]                                  m_axi_awsize,
  output logic [1:0]                                  m_axi_awburst,
  output logic                                        m_axi_awvalid,
  input  logic                                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]                   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                 m_axi_wstrb,
  output logic                                        m_axi_wlast,
  output logic                                        m_axi_wvalid,
  input  logic                                        m_axi_wready,
  input  logic [1:0]                                  m_axi_bresp,
  input  logic                                        m_axi_bvalid,
  output logic                                        m_axi_bready,
  output logic [2:0]                                  dbg_state
);

  // Handshakes: a transfer happens on any cycle where valid && ready; the
  // master holds valid and payload stable until that cycle.

  localparam int EPB  = AXI_DATA_WIDTH / ACCUM_WIDTH;
  localparam int SIZE = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  dump_state_e state, state_nxt;

  logic [LEN_W-1:0] m_q, n_q, beats_q, row_q, beat_q, seg_last_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0] stride_q, row_addr_q, seg_addr_q;
  logic [SYSTOLIC_ARRAY_WIDTH*ACCUM_WIDTH-1:0] row_data_q;
  logic [7:0] rd_cnt_q;
  logic err_q;

  logic [LEN_W-1:0] m_clamp, n_clamp;
  logic [31:0] to_bnd, remain, seg_beats;
  logic rd_done, row_finished, last_row;
  logic [AXI_DATA_WIDTH-1:0] pk_data;
  logic [AXI_DATA_WIDTH/8-1:0] pk_strb;

  assign m_clamp = (m_len > MAX_LEN) ? MAX_LEN : m_len;
  assign n_clamp = (n_len > MAX_LEN) ? MAX_LEN : n_len;

  // A burst may only run up to the next 4 KB page; addresses are beat aligned.
  assign to_bnd       = (BOUNDARY_4K - {20'd0, seg_addr_q[11:0]}) >> SIZE;
  assign remain       = 32'(beats_q - beat_q);
  assign seg_beats    = (remain < to_bnd) ? remain : to_bnd;
  assign rd_done      = (rd_cnt_q == 8'(BUF_RD_LATENCY));
  assign row_finished = (beat_q == beats_q);
  assign last_row     = (row_q == m_q - ONE);

  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign err           = err_q;
  assign dbg_state     = state;

  tpu_dump_beat_packer #(
    .AXI_DATA_WIDTH      (AXI_DATA_WIDTH),
    .ACCUM_WIDTH         (ACCUM_WIDTH),
    .SYSTOLIC_ARRAY_WIDTH(SYSTOLIC_ARRAY_WIDTH),
    .LEN_W               (LEN_W)
  ) u_packer (
    .row_data(row_data_q),
    .beat_idx(beat_q),
    .n_len   (n_q),
    .wdata   (pk_data),
    .wstrb   (pk_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    buf_rd_en     = 1'b0;
    buf_rd_addr   = '0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (m_clamp == '0 || n_clamp == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        busy = 1'b1;
        if (rd_cnt_q == 8'd0) begin
          buf_rd_en   = 1'b1;
          buf_rd_addr = base_q + ADDR_WIDTH'(row_q);
        end
        if (rd_done) state_nxt = S_AW;
      end
      S_AW: begin
        busy          = 1'b1;
        m_axi_awvalid = 1'b1;
        m_axi_awaddr  = seg_addr_q;
        m_axi_awlen   = 8'(seg_beats - 32'd1);
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        busy         = 1'b1;
        m_axi_wvalid = 1'b1;
        m_axi_wdata  = pk_data;
        m_axi_wstrb  = pk_strb;
        m_axi_wlast  = (beat_q == seg_last_q);
        if (m_axi_wready && m_axi_wlast) state_nxt = S_B;
      end
      S_B: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (!row_finished) state_nxt = S_AW;
          else if (last_row) state_nxt = S_DONE;
          else               state_nxt = S_RD;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q        <= '0;
      n_q        <= '0;
      beats_q    <= '0;
      row_q      <= '0;
      beat_q     <= '0;
      seg_last_q <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      row_addr_q <= '0;
      seg_addr_q <= '0;
      row_data_q <= '0;
      rd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          m_q        <= m_clamp;
          n_q        <= n_clamp;
          beats_q    <= LEN_W'(beats_for(32'(n_clamp), 32'(EPB)));
          base_q     <= buf_base;
          stride_q   <= ddr_stride;
          row_addr_q <= ddr_addr;
          seg_addr_q <= ddr_addr;
          row_q      <= '0;
          beat_q     <= '0;
          rd_cnt_q   <= '0;
          err_q      <= 1'b0;
        end
        S_RD: begin
          rd_cnt_q <= rd_cnt_q + 8'd1;
          if (rd_done) begin
            row_data_q <= buf_rd_data;
            rd_cnt_q   <= '0;
          end
        end
        S_AW: if (m_axi_awready) begin
          seg_last_q <= beat_q + LEN_W'(seg_beats) - ONE;
          seg_addr_q <= seg_addr_q + (seg_beats << SIZE);
        end
        S_W: if (m_axi_wready) beat_q <= beat_q + ONE;
        S_B: if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
          // Row complete: advance to the next row's base address.
          if (row_finished) begin
            row_q      <= row_q + ONE;
            beat_q     <= '0;
            row_addr_q <= row_addr_q + stride_q;
            seg_addr_q <= row_addr_q + stride_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_result_dump_engine.sv
// Self-checking bench for tpu_result_dump_engine: AXI slave model with optional
// backpressure, result-buffer model, and a scoreboard of expected bursts/beats.
module tb_tpu_result_dump_engine;

  localparam int ADW = 64, ACC = 32, SAW = 16, AWD = 10, LEN_W = 5;

  logic clk = 1'b0;
  logic rst, start;
  logic [LEN_W-1:0] m_len, n_len;
  logic [AWD-1:0] buf_base;
  logic [31:0] ddr_addr, ddr_stride;
  logic busy, done, err, buf_rd_en;
  logic [AWD-1:0] buf_rd_addr;
  logic [SAW*ACC-1:0] buf_rd_data;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [ADW-1:0] wdata;
  logic [ADW/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  tpu_result_dump_engine dut (
    .clk(clk), .rst(rst), .start(start), .m_len(m_len), .n_len(n_len),
    .buf_base(buf_base), .ddr_addr(ddr_addr), .ddr_stride(ddr_stride),
    .busy(busy), .done(done), .err(err),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .dbg_state(dbg_state)
  );

  logic [SAW*ACC-1:0] buf_mem [0:(1<<AWD)-1];
  logic [39:0] exp_aw_q[$];
  logic [ADW+ADW/8:0] exp_w_q[$];

  int n_cmp = 0, n_bad = 0;
  int aw_cnt = 0, w_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int err_burst = -1;
  bit bp_en = 0;
  bit b_pend = 0, b_take = 0, w_stall = 0, aw_stall = 0;
  logic [ADW-1:0] hold_data;
  logic [ADW/8-1:0] hold_strb;
  logic [39:0] hold_aw;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Result buffer: one-cycle registered read.
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= buf_mem[buf_rd_addr];

  // AXI slave and monitors, all evaluated at the falling edge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; buf_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; b_pend = 0; b_take = 0;
        w_stall = 0; aw_stall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (buf_rd_en) rd_cnt++;
      if (b_take) begin
        bvalid = 0; b_take = 0;
      end else if (b_pend && !bvalid && (!bp_en || $urandom_range(0, 1) == 1)) begin
        bvalid = 1; b_pend = 0;
        bresp = (aw_cnt - 1 == err_burst) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) b_take = 1;

      if (aw_stall) check_eq("aw_hold", {awvalid, awaddr, awlen}, {1'b1, hold_aw});
      awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (awvalid && awready) begin
        check_eq("aw_expected", 128'(exp_aw_q.size() > 0), 128'd1);
        if (exp_aw_q.size() > 0) check_eq("aw_addr_len", {awaddr, awlen}, exp_aw_q.pop_front());
        aw_cnt++;
      end
      aw_stall = awvalid && !awready;
      hold_aw = {awaddr, awlen};

      if (w_stall) check_eq("w_hold", {wvalid, wdata, wstrb}, {1'b1, hold_data, hold_strb});
      wready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid && wready) begin
        check_eq("w_expected", 128'(exp_w_q.size() > 0), 128'd1);
        if (exp_w_q.size() > 0) check_eq("w_beat", {wdata, wstrb, wlast}, exp_w_q.pop_front());
        if (wlast) b_pend = 1;
        w_cnt++;
      end
      w_stall = wvalid && !wready;
      hold_data = wdata;
      hold_strb = wstrb;
    end
  end

  task automatic fill_buf(input int base, input int m, input bit const_37, input logic [31:0] ofs);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < SAW; c++)
        buf_mem[base + r][c*ACC +: ACC] = const_37 ? 32'd37 : (32'(r * 16 + c) + ofs);
  endtask

  task automatic push_expected(input int m, input int n, input int base,
                               input logic [31:0] addr, input logic [31:0] stride);
    for (int r = 0; r < m; r++) begin
      logic [31:0] a;
      logic [SAW*ACC-1:0] rowv;
      int total, beat, seg, to_bnd;
      a = addr + stride * 32'(r);
      rowv = buf_mem[base + r];
      total = (n + 1) / 2;
      beat = 0;
      while (beat < total) begin
        to_bnd = (4096 - int'(a & 32'hFFF)) / 8;
        seg = (total - beat < to_bnd) ? total - beat : to_bnd;
        exp_aw_q.push_back({a, 8'(seg - 1)});
        for (int b = beat; b < beat + seg; b++) begin
          logic [ADW-1:0] d;
          logic [ADW/8-1:0] s;
          d = '0; s = '0;
          for (int l = 0; l < 2; l++)
            if (b * 2 + l < n) begin
              d[l*ACC +: ACC] = rowv[(b*2+l)*ACC +: ACC];
              s[l*4 +: 4] = 4'hF;
            end
          exp_w_q.push_back({d, s, 1'(b == beat + seg - 1)});
        end
        a = a + 32'(seg * 8);
        beat += seg;
      end
    end
  endtask

  task automatic run_dump(input string name, input int m, input int n, input int base,
                          input logic [31:0] addr, input logic [31:0] stride,
                          input bit second_start, input bit exp_err);
    int d0, a0, r0, cyc;
    push_expected(m, n, base, addr, stride);
    d0 = done_cnt; a0 = aw_cnt; r0 = rd_cnt;
    m_len = LEN_W'(m); n_len = LEN_W'(n); buf_base = AWD'(base);
    ddr_addr = addr; ddr_stride = stride;
    start = 1;
    step();
    start = 0;
    if (m == 0 || n == 0) begin
      check_eq({name, "_done_next"}, 128'({done, busy}), 128'(2'b10));
    end else begin
      check_eq({name, "_busy"}, 128'(busy), 128'd1);
      check_eq({name, "_err_clr"}, 128'(err), 128'd0);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 6000) begin
      step();
      cyc++;
      start = (second_start && cyc == 30);
    end
    start = 0;
    check_eq({name, "_timeout"}, 128'(cyc < 6000), 128'd1);
    repeat (6) step();
    check_eq({name, "_done_cnt"}, 128'(done_cnt - d0), 128'd1);
    check_eq({name, "_aw_left"}, 128'(exp_aw_q.size()), 128'd0);
    check_eq({name, "_w_left"}, 128'(exp_w_q.size()), 128'd0);
    check_eq({name, "_err"}, 128'(err), 128'(exp_err));
    check_eq({name, "_idle"}, 128'({busy, dbg_state}), 128'd0);
    if (m == 0 || n == 0) begin
      check_eq({name, "_no_rd"}, 128'(rd_cnt - r0), 128'd0);
      check_eq({name, "_no_aw"}, 128'(aw_cnt - a0), 128'd0);
    end else begin
      check_eq({name, "_rows_read"}, 128'(rd_cnt - r0), 128'(m));
    end
    exp_aw_q.delete();
    exp_w_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; m_len = 0; n_len = 0; buf_base = 0; ddr_addr = 0; ddr_stride = 0;
    repeat (3) step();
    check_eq("reset_outs",
             {busy, done, err, buf_rd_en, buf_rd_addr, awvalid, awaddr, awlen,
              wvalid, wdata, wstrb, wlast, bready, dbg_state}, 128'd0);
    check_eq("reset_awsize", 128'(awsize), 128'd3);
    check_eq("reset_awburst", 128'(awburst), 128'd1);
    rst = 0;
    step();

    fill_buf(0, 16, 1'b1, 32'd0);
    run_dump("full37", 16, 16, 0, 32'h8000_0000, 32'd64, 1'b0, 1'b0);

    fill_buf(5, 3, 1'b0, 32'hA000);
    run_dump("m3n5", 3, 5, 5, 32'h8000_2000, 32'h100, 1'b0, 1'b0);

    fill_buf(40, 1, 1'b0, 32'hB000);
    run_dump("split4k", 1, 16, 40, 32'h8000_0FF0, 32'd64, 1'b0, 1'b0);

    fill_buf(100, 16, 1'b0, 32'd0);
    bp_en = 1;
    run_dump("backpr", 16, 16, 100, 32'h9000_0F80, 32'd72, 1'b0, 1'b0);
    bp_en = 0;

    err_burst = aw_cnt + 2;
    run_dump("slverr", 16, 16, 100, 32'h8000_0000, 32'd64, 1'b0, 1'b1);
    err_burst = -1;

    run_dump("errclr", 2, 3, 100, 32'hFFFF_FFF8, 32'd16, 1'b0, 1'b0);

    run_dump("m0", 0, 16, 0, 32'h8000_0000, 32'd64, 1'b0, 1'b0);

    run_dump("restart", 16, 16, 0, 32'h8000_0000, 32'd64, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
